// File: rtl/alu_pkg.sv
// alu_pkg: ALU command encodings, NZCV bit positions and lock-owner encodings shared by the arbiter
package alu_pkg;
  localparam logic [3:0] CMD_IDLE = 4'b0000;
  localparam logic [3:0] CMD_MOV  = 4'b0001;
  localparam logic [3:0] CMD_MVN  = 4'b1001;
  localparam logic [3:0] CMD_ADD  = 4'b0010;
  localparam logic [3:0] CMD_ADC  = 4'b0011;
  localparam logic [3:0] CMD_SUB  = 4'b0100;
  localparam logic [3:0] CMD_CMP  = 4'b0100;
  localparam logic [3:0] CMD_SBC  = 4'b0101;
  localparam logic [3:0] CMD_AND  = 4'b0110;
  localparam logic [3:0] CMD_TST  = 4'b0110;
  localparam logic [3:0] CMD_ORR  = 4'b0111;
  localparam logic [3:0] CMD_EOR  = 4'b1000;
  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;
  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_P0   = 2'd1,
    LOCK_P1   = 2'd2
  } lock_e;
  function automatic lock_e lock_of(input logic port);
    return port ? LOCK_P1 : LOCK_P0;
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; a lock owner excludes the other port entirely
module rr_arb2
  import alu_pkg::*;
(
  input  logic [1:0] elig,
  input  logic       last_grant,
  input  lock_e      lock_owner,
  output logic [1:0] gnt
);
  always_comb
    gnt = lock_owner == LOCK_P0 ? {1'b0, elig[0]} :
          lock_owner == LOCK_P1 ? {elig[1], 1'b0} :
          &elig                 ? (last_grant ? 2'b01 : 2'b10) : elig;
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between two requesters with round-robin/lock arbitration, owns NZCV
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CMD_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [1:0][CMD_W-1:0]     req_cmd,
  input  logic [1:0][DW-1:0]        req_val1,
  input  logic [1:0][DW-1:0]        req_val2,
  input  logic [1:0]                req_s,
  input  logic [1:0]                req_lock,
  output logic [1:0]                rsp_valid,
  input  logic [1:0]                rsp_ready,
  output logic [1:0][DW-1:0]        rsp_result,
  output logic [1:0][3:0]           rsp_nzcv,
  output logic [DW-1:0]             alu_val1,
  output logic [DW-1:0]             alu_val2,
  output logic [CMD_W-1:0]          alu_exe_cmd,
  output logic [3:0]                alu_status,
  input  logic [DW-1:0]             alu_out,
  input  logic [3:0]                alu_status_out,
  output logic [3:0]                nzcv
);
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [1:0][DW-1:0]  rsp_result_q, rsp_result_d;
  logic [1:0][3:0]     rsp_nzcv_q, rsp_nzcv_d;
  logic [3:0]          nzcv_q, nzcv_d;
  logic                last_grant_q, last_grant_d;
  lock_e               lock_q, lock_d;
  logic [1:0]          elig, gnt;
  logic                sel, any;
  // a slot being drained this cycle can be refilled in the same cycle; nothing is granted in reset
  assign elig = {2{rst_n}} & req_valid & (~rsp_valid_q | rsp_ready);
  rr_arb2 u_arb (
    .elig       (elig),
    .last_grant (last_grant_q),
    .lock_owner (lock_q),
    .gnt        (gnt)
  );
  always_comb begin
    sel             = gnt[1];
    any             = |gnt;
    alu_val1        = any ? req_val1[sel] : '0;
    alu_val2        = any ? req_val2[sel] : '0;
    alu_exe_cmd     = any ? req_cmd[sel] : '0;
    rsp_valid_d     = gnt | (rsp_valid_q & ~rsp_ready);
    rsp_result_d[0] = gnt[0] ? alu_out : rsp_result_q[0];
    rsp_result_d[1] = gnt[1] ? alu_out : rsp_result_q[1];
    rsp_nzcv_d[0]   = gnt[0] ? alu_status_out : rsp_nzcv_q[0];
    rsp_nzcv_d[1]   = gnt[1] ? alu_status_out : rsp_nzcv_q[1];
    nzcv_d          = any && req_s[sel] ? alu_status_out : nzcv_q;
    last_grant_d    = any ? sel : last_grant_q;
    lock_d          = !any ? lock_q : req_lock[sel] ? lock_of(sel) : LOCK_NONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_nzcv_q   <= '0;
      nzcv_q       <= '0;
      last_grant_q <= 1'b1;
      lock_q       <= LOCK_NONE;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_nzcv_q   <= rsp_nzcv_d;
      nzcv_q       <= nzcv_d;
      last_grant_q <= last_grant_d;
      lock_q       <= lock_d;
    end
  assign req_ready  = gnt;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_nzcv   = rsp_nzcv_q;
  assign nzcv       = nzcv_q;
  assign alu_status = nzcv_q;
endmodule
